m_mic_req: RTL and testbench

Single-outstanding MIC requester: accepts simple read/write commands from a local client, emits MIC request packets (header plus write-data beats) on the request channel, and consumes the RDATA/WRACK response packet on the response channel. It is the initiator end of the MIC read/write protocol, sitting between a CPU/DMA-style client and the MIC interconnect, opposite memory responders.

---
 rtl/mic_pkg.sv | 28 ++
 rtl/m_mic_req.sv | 138 +++++++++++++
 tb/tb_m_mic_req.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mic_pkg.sv
// mic_pkg: MIC packet-type codes, header field positions and a header pack helper shared by requesters and responders
package mic_pkg;
  localparam logic [1:0] PKT_READ  = 2'b00;
  localparam logic [1:0] PKT_WRITE = 2'b01;
  localparam logic [1:0] PKT_RDATA = 2'b10;
  localparam logic [1:0] PKT_WRACK = 2'b11;
  localparam int BEN_HI  = 63;
  localparam int BEN_LO  = 59;
  localparam int SRC_HI  = 55;
  localparam int SRC_LO  = 48;
  localparam int LEN_HI  = 47;
  localparam int LEN_LO  = 40;
  localparam int TYPE_HI = 33;
  localparam int TYPE_LO = 32;
  localparam int ADDR_HI = 31;
  localparam int ADDR_LO = 3;
  function automatic logic [63:0] hdr_pack(input logic [4:0] ben, input logic [7:0] src, input logic [7:0] len,
                                           input logic [1:0] typ, input logic [28:0] addr);
    logic [63:0] h;
    h = '0;
    h[BEN_HI:BEN_LO]   = ben;
    h[SRC_HI:SRC_LO]   = src;
    h[LEN_HI:LEN_LO]   = len;
    h[TYPE_HI:TYPE_LO] = typ;
    h[ADDR_HI:ADDR_LO] = addr;
    return h;
  endfunction
endpackage

// File: rtl/m_mic_req.sv
// m_mic_req: single-outstanding MIC requester turning client read/write commands into MIC request/response packets
// Ports: clk; reset (async, active-low); cmd_* command handshake; wd_* write-data stream in; rd_* read-data stream out;
//        done/err completion pulses; O_T* request channel (out); I_T* response channel (in).
module m_mic_req
  import mic_pkg::*;
#(
  parameter logic [7:0] SRC_ID = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [28:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [4:0]  cmd_ben,
  input  logic        wd_valid,
  output logic        wd_ready,
  input  logic [63:0] wd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [63:0] rd_data,
  output logic        rd_last,
  output logic        done,
  output logic        err,
  output logic        O_TVALID,
  input  logic        O_TREADY,
  output logic [63:0] O_TDATA,
  output logic        O_TLAST,
  input  logic        I_TVALID,
  output logic        I_TREADY,
  input  logic [63:0] I_TDATA,
  input  logic        I_TLAST
);
  typedef enum logic [2:0] {IDLE, REQ_HDR, REQ_DATA, RESP_HDR, RESP_DATA, DRAIN} state_e;
  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [28:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [4:0]  ben_q, ben_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        eflag_q, eflag_d, done_q, done_d, err_q, err_d;
  logic        at_len, hdr_ok;
  assign at_len    = cnt_q == {1'b0, len_q};
  assign hdr_ok    = I_TDATA[SRC_HI:SRC_LO] == SRC_ID && I_TDATA[TYPE_HI:TYPE_LO] == (wr_q ? PKT_WRACK : PKT_RDATA);
  assign cmd_ready = state_q == IDLE;
  assign O_TVALID  = state_q == REQ_HDR || (state_q == REQ_DATA && wd_valid);
  assign O_TDATA   = state_q == REQ_HDR ? hdr_pack(ben_q, SRC_ID, wr_q ? 8'h00 : len_q, wr_q ? PKT_WRITE : PKT_READ, addr_q)
                   : state_q == REQ_DATA ? wd_data : '0;
  assign O_TLAST   = state_q == REQ_HDR ? !wr_q : (state_q == REQ_DATA && at_len);
  assign wd_ready  = state_q == REQ_DATA && O_TREADY;
  assign I_TREADY  = state_q == RESP_HDR || state_q == DRAIN || (state_q == RESP_DATA && rd_ready);
  assign rd_valid  = state_q == RESP_DATA && I_TVALID;
  assign rd_data   = state_q == RESP_DATA ? I_TDATA : '0;
  assign rd_last   = state_q == RESP_DATA && I_TLAST;
  assign done      = done_q;
  assign err       = err_q;
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    len_d   = len_q;
    ben_d   = ben_q;
    cnt_d   = cnt_q;
    eflag_d = eflag_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        wr_d    = cmd_write;
        addr_d  = cmd_addr;
        len_d   = cmd_len;
        ben_d   = cmd_ben;
        eflag_d = 1'b0;
        state_d = REQ_HDR;
      end
      REQ_HDR: if (O_TREADY) begin
        cnt_d   = '0;
        state_d = wr_q ? REQ_DATA : RESP_HDR;
      end
      REQ_DATA: if (wd_valid && O_TREADY) begin
        cnt_d   = cnt_q + 9'd1;
        state_d = at_len ? RESP_HDR : REQ_DATA;
      end
      RESP_HDR: if (I_TVALID) begin
        if (hdr_ok && wr_q && I_TLAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (hdr_ok && !wr_q && !I_TLAST) begin
          cnt_d   = '0;
          state_d = RESP_DATA;
        end else begin
          eflag_d = 1'b1;
          done_d  = I_TLAST;
          err_d   = I_TLAST;
          state_d = I_TLAST ? IDLE : DRAIN;
        end
      end
      RESP_DATA: if (I_TVALID && rd_ready) begin
        cnt_d   = cnt_q + 9'd1;
        // an overrun beat is flagged so a later counter wrap cannot hide it
        eflag_d = eflag_q || (at_len && !I_TLAST);
        done_d  = I_TLAST;
        err_d   = I_TLAST && (eflag_q || !at_len);
        state_d = I_TLAST ? IDLE : RESP_DATA;
      end
      DRAIN: if (I_TVALID && I_TLAST) begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      ben_q   <= '0;
      cnt_q   <= '0;
      eflag_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      ben_q   <= ben_d;
      cnt_q   <= cnt_d;
      eflag_q <= eflag_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_m_mic_req.sv
// tb_m_mic_req: directed and randomized transactions against a packet-level model of the MIC requester
module tb_m_mic_req;
  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [28:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [4:0]  cmd_ben;
  logic        wd_valid, wd_ready;
  logic [63:0] wd_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [63:0] rd_data;
  logic        done, err;
  logic        O_TVALID, O_TREADY, O_TLAST;
  logic [63:0] O_TDATA;
  logic        I_TVALID, I_TREADY, I_TLAST;
  logic [63:0] I_TDATA;
  logic [63:0] last_hdr;
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  m_mic_req dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_ben(cmd_ben),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .err(err),
    .O_TVALID(O_TVALID), .O_TREADY(O_TREADY), .O_TDATA(O_TDATA), .O_TLAST(O_TLAST),
    .I_TVALID(I_TVALID), .I_TREADY(I_TREADY), .I_TDATA(I_TDATA), .I_TLAST(I_TLAST)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  function automatic bit coin();
    return $urandom_range(0, 1) == 1;
  endfunction

  // One complete transaction: the bench plays client and responder. Expected behaviour comes
  // from packet-level rules: the header a command should produce, whether the response is
  // acceptable, and which response beats must appear on rd_*.
  task automatic txn(input bit wr, input logic [28:0] addr, input logic [7:0] len, input logic [4:0] ben,
                     input logic [7:0] rsrc, input logic [1:0] rtyp, input int nbeats, input int stall, input int gap);
    logic [63:0] hdr, r;
    logic [63:0] rsp[$];
    bit good, eerr, pass, xfer;
    int i, t;
    hdr  = {ben, 3'b000, 8'h00, (wr ? 8'h00 : len), 6'b000000, (wr ? 2'b01 : 2'b00), addr, 3'b000};
    good = rsrc == 8'h00 && rtyp == (wr ? 2'b11 : 2'b10);
    eerr = !(good && nbeats == (wr ? 0 : int'(len) + 1));
    pass = good && !wr && nbeats > 0;
    r = {$urandom, $urandom};
    r[55:48] = rsrc;
    r[33:32] = rtyp;
    rsp.push_back(r);
    for (int k = 0; k < nbeats; k++) rsp.push_back({$urandom, $urandom});
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_ben = ben;
    I_TVALID = 1'b1; I_TDATA = rsp[0]; I_TLAST = rsp.size() == 1;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    chk("tvalid_idle", O_TVALID, 0);
    chk("done_one_cycle", done, 0);
    chk("itready_idle", I_TREADY, 0);
    cyc;
    cmd_valid = 1'b0; cmd_write = !wr; cmd_addr = 29'($urandom); cmd_len = 8'($urandom); cmd_ben = 5'($urandom);
    for (int k = 0; k <= stall; k++) begin
      O_TREADY = k == stall;
      @(negedge clk);
      if (k == 0) last_hdr = O_TDATA;
      chk("hdr_tvalid", O_TVALID, 1);
      chk("hdr_tdata", O_TDATA, hdr);
      chk("hdr_tlast", O_TLAST, !wr);
      chk("hdr_cmd_ready", cmd_ready, 0);
      chk("hdr_itready", I_TREADY, 0);
      cyc;
    end
    O_TREADY = 1'b0;
    if (wr) begin
      i = 0; t = 0;
      while (i <= int'(len) && t < 5000) begin
        wd_valid = gap == 0 || coin();
        wd_data  = {$urandom, $urandom};
        O_TREADY = gap == 0 || coin();
        @(negedge clk);
        chk("wd_tvalid", O_TVALID, wd_valid);
        chk("wd_ready", wd_ready, O_TREADY);
        chk("wd_itready", I_TREADY, 0);
        if (wd_valid && O_TREADY) begin
          chk("wd_tdata", O_TDATA, wd_data);
          chk("wd_tlast", O_TLAST, i == int'(len));
          i++;
        end
        cyc;
        t++;
      end
      wd_valid = 1'b0; O_TREADY = 1'b0;
      chk("wd_in_time", t < 5000, 1);
    end
    i = 0; t = 0;
    while (i < rsp.size() && t < 5000) begin
      I_TVALID = gap == 0 || coin();
      I_TDATA  = rsp[i];
      I_TLAST  = i == rsp.size() - 1;
      rd_ready = gap == 0 || coin();
      @(negedge clk);
      chk("rsp_no_done", done, 0);
      if (i > 0 && pass) begin
        chk("rd_valid", rd_valid, I_TVALID);
        chk("rd_itready", I_TREADY, rd_ready);
        if (I_TVALID) begin
          chk("rd_data", rd_data, rsp[i]);
          chk("rd_last", rd_last, I_TLAST);
        end
        xfer = I_TVALID && rd_ready;
      end else begin
        chk("rsp_hidden", rd_valid, 0);
        chk("rsp_itready", I_TREADY, 1);
        xfer = I_TVALID;
      end
      cyc;
      if (xfer) i++;
      t++;
    end
    I_TVALID = 1'b0; I_TLAST = 1'b0; rd_ready = 1'b0;
    chk("rsp_in_time", t < 5000, 1);
    @(negedge clk);
    chk("done", done, 1);
    chk("err", err, eerr);
    chk("done_idle", cmd_ready, 1);
    cyc;
  endtask

  initial begin
    bit          w;
    logic [7:0]  l;
    logic [7:0]  src;
    logic [1:0]  typ;
    int          sel, nb;
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_ben = '0;
    wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0; O_TREADY = 1'b0;
    I_TVALID = 1'b0; I_TDATA = '0; I_TLAST = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_tvalid", O_TVALID, 0);
    chk("rst_tdata", O_TDATA, 0);
    chk("rst_tlast", O_TLAST, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_itready", I_TREADY, 0);
    cyc;
    reset = 1'b1;
    cyc;
    txn(1'b0, 29'h200, 8'd3, 5'h00, 8'h00, 2'b10, 4, 0, 0);
    chk("read_hdr_const", last_hdr, 64'h0000_0300_0000_1000);
    txn(1'b1, 29'($urandom), 8'd1, 5'h1f, 8'h00, 2'b11, 0, 3, 0);
    txn(1'b0, 29'($urandom), 8'd255, 5'($urandom), 8'h00, 2'b10, 256, 0, 1);
    txn(1'b0, 29'($urandom), 8'd3, 5'($urandom), 8'h5a, 2'b10, 2, 0, 0);
    txn(1'b0, 29'($urandom), 8'd3, 5'($urandom), 8'h00, 2'b10, 2, 0, 0);
    txn(1'b0, 29'($urandom), 8'd2, 5'($urandom), 8'h00, 2'b10, 5, 1, 1);
    for (int n = 0; n < 24; n++) begin
      w   = coin();
      l   = 8'($urandom_range(0, 15));
      sel = $urandom_range(0, 5);
      src = sel == 1 ? 8'($urandom_range(1, 255)) : 8'h00;
      typ = sel == 2 ? (w ? 2'b10 : 2'b11) : (w ? 2'b11 : 2'b10);
      nb  = sel == 3 ? $urandom_range(0, int'(l) + 2) : (w ? 0 : int'(l) + 1);
      txn(w, 29'($urandom), l, 5'($urandom), src, typ, nb, $urandom_range(0, 2), $urandom_range(0, 1));
    end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 29'($urandom); cmd_len = 8'd3; cmd_ben = 5'h03;
    @(negedge clk);
    cyc;
    cmd_valid = 1'b0; O_TREADY = 1'b1;
    @(negedge clk);
    cyc;
    wd_valid = 1'b1; wd_data = {$urandom, $urandom};
    @(negedge clk);
    chk("mid_tvalid", O_TVALID, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_tvalid", O_TVALID, 0);
    chk("arst_tdata", O_TDATA, 0);
    chk("arst_tlast", O_TLAST, 0);
    chk("arst_wd_ready", wd_ready, 0);
    chk("arst_rd_valid", rd_valid, 0);
    chk("arst_itready", I_TREADY, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    wd_valid = 1'b0; O_TREADY = 1'b0;
    cyc;
    cyc;
    #3 reset = 1'b1;
    cyc;
    txn(1'b0, 29'($urandom), 8'd5, 5'($urandom), 8'h00, 2'b10, 6, 1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
